// File: rtl/keyboard_state_decoder_pkg.sv
// Shared definitions for the PS/2 keyboard state decoder.
// - Key-index macros, NUMBEROFKEYBOARDINPUTS and the scan-code tables as macros.
// - Package: FSM state type, prefix/control byte constants and byte classifiers.
// Ports: none (package only).

`ifndef KEYBOARD_STATE_DECODER_DEFS
`define KEYBOARD_STATE_DECODER_DEFS

`define NUMBEROFKEYBOARDINPUTS 20

// Key indices into inputStateStorage
`define keySpacebar 5'd0
`define keyEnter    5'd1
`define keyR        5'd2
`define keyNoteC    5'd3
`define keyNoteCs   5'd4
`define keyNoteD    5'd5
`define keyNoteDs   5'd6
`define keyNoteE    5'd7
`define keyNoteF    5'd8
`define keyNoteFs   5'd9
`define keyNoteG    5'd10
`define keyNoteGs   5'd11
`define keyNoteA    5'd12
`define keyNoteAs   5'd13
`define keyNoteB    5'd14
`define keyNoteC2   5'd15
`define keyUp       5'd16
`define keyDown     5'd17
`define keyLeft     5'd18
`define keyRight    5'd19

// Scan-code set 2, plain (non-extended) table
`define SC_SPACEBAR 8'h29
`define SC_ENTER    8'h5A
`define SC_R        8'h2D
`define SC_NOTE_C   8'h1C
`define SC_NOTE_CS  8'h1D
`define SC_NOTE_D   8'h1B
`define SC_NOTE_DS  8'h24
`define SC_NOTE_E   8'h23
`define SC_NOTE_F   8'h2B
`define SC_NOTE_FS  8'h2C
`define SC_NOTE_G   8'h34
`define SC_NOTE_GS  8'h35
`define SC_NOTE_A   8'h33
`define SC_NOTE_AS  8'h3C
`define SC_NOTE_B   8'h3B
`define SC_NOTE_C2  8'h42

// Scan-code set 2, extended (E0-prefixed) table
`define SC_EXT_UP    8'h75
`define SC_EXT_DOWN  8'h72
`define SC_EXT_LEFT  8'h6B
`define SC_EXT_RIGHT 8'h74

`endif

package keyboard_state_decoder_pkg;

  localparam int unsigned NUM_KEYS = `NUMBEROFKEYBOARDINPUTS;

  localparam logic [4:0] KEY_SPACEBAR = `keySpacebar;
  localparam logic [4:0] KEY_ENTER    = `keyEnter;
  localparam logic [4:0] KEY_R        = `keyR;

  localparam logic [7:0] SC_BREAK_PFX = 8'hF0;
  localparam logic [7:0] SC_EXT_PFX   = 8'hE0;
  localparam logic [7:0] SC_PAUSE_PFX = 8'hE1;

  // Bytes that follow E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK,
    ST_PAUSE_SKIP
  } state_t;

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Keyboard acknowledge / self-test / resend bytes
  function automatic logic is_ack(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/scancode_lookup.sv
// Combinational scan-code to key-index map.
// Ports:
//   extended - 1: code followed an E0 prefix (extended table)
//   code     - scan-code byte
//   hit      - 1 when the code is mapped
//   index    - key index into the state vector (0 when no hit)

module scancode_lookup (
  input  logic       extended,
  input  logic [7:0] code,
  output logic       hit,
  output logic [4:0] index
);

  always_comb begin
    hit   = 1'b1;
    index = '0;
    case ({extended, code})
      {1'b0, `SC_SPACEBAR}:  index = `keySpacebar;
      {1'b0, `SC_ENTER}:     index = `keyEnter;
      {1'b0, `SC_R}:         index = `keyR;
      {1'b0, `SC_NOTE_C}:    index = `keyNoteC;
      {1'b0, `SC_NOTE_CS}:   index = `keyNoteCs;
      {1'b0, `SC_NOTE_D}:    index = `keyNoteD;
      {1'b0, `SC_NOTE_DS}:   index = `keyNoteDs;
      {1'b0, `SC_NOTE_E}:    index = `keyNoteE;
      {1'b0, `SC_NOTE_F}:    index = `keyNoteF;
      {1'b0, `SC_NOTE_FS}:   index = `keyNoteFs;
      {1'b0, `SC_NOTE_G}:    index = `keyNoteG;
      {1'b0, `SC_NOTE_GS}:   index = `keyNoteGs;
      {1'b0, `SC_NOTE_A}:    index = `keyNoteA;
      {1'b0, `SC_NOTE_AS}:   index = `keyNoteAs;
      {1'b0, `SC_NOTE_B}:    index = `keyNoteB;
      {1'b0, `SC_NOTE_C2}:   index = `keyNoteC2;
      {1'b1, `SC_EXT_UP}:    index = `keyUp;
      {1'b1, `SC_EXT_DOWN}:  index = `keyDown;
      {1'b1, `SC_EXT_LEFT}:  index = `keyLeft;
      {1'b1, `SC_EXT_RIGHT}: index = `keyRight;
      default:               hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/keyboard_state_decoder.sv
// PS/2 scan-code set 2 decoder that keeps a held-key state vector.
// Ports:
//   clk, resetn        - clock (rising edge), async active-low reset
//   ps2Byte/Valid      - received byte and its one-cycle qualifier
//   inputStateStorage  - held key state, 1 = down
//   keyEventValid      - one-cycle pulse on a key-state bit change
//   keyEventIndex      - changed key index, valid with keyEventValid
//   keyEventPressed    - 1 = press, 0 = release, valid with keyEventValid
//   decodeError        - one-cycle pulse on overrun byte or prefix timeout

module keyboard_state_decoder
  import keyboard_state_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned NKEYS          = `NUMBEROFKEYBOARDINPUTS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2Byte,
  input  logic             ps2ByteValid,
  output logic [NKEYS-1:0] inputStateStorage,
  output logic             keyEventValid,
  output logic [4:0]       keyEventIndex,
  output logic             keyEventPressed,
  output logic             decodeError
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [2:0]       skip_cnt, skip_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;

  // Decode actions produced by the next-state logic
  logic lk_req, lk_ext, lk_make, overrun, timeout;
  logic lk_hit;
  logic [4:0] lk_index;

  logic [NKEYS-1:0] keys_next;
  logic             ev_valid_next, ev_pressed_next, err_next;
  logic [4:0]       ev_index_next;

  scancode_lookup u_lookup (
    .extended (lk_ext),
    .code     (ps2Byte),
    .hit      (lk_hit),
    .index    (lk_index)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      tmo_cnt  <= tmo_next;
    end
  end

  // Next-state logic. A valid byte always wins over timeout expiry in the
  // same cycle because the timeout branch is only taken without a byte.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    tmo_next   = tmo_cnt;
    lk_req     = 1'b0;
    lk_ext     = 1'b0;
    lk_make    = 1'b0;
    overrun    = 1'b0;
    timeout    = 1'b0;
    if (ps2ByteValid) begin
      tmo_next = '0;
      if (is_overrun(ps2Byte)) begin
        overrun    = 1'b1;
        state_next = ST_IDLE;
        skip_next  = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ps2Byte == SC_BREAK_PFX) begin
              state_next = ST_BREAK;
            end else if (ps2Byte == SC_EXT_PFX) begin
              state_next = ST_EXT;
            end else if (ps2Byte == SC_PAUSE_PFX) begin
              state_next = ST_PAUSE_SKIP;
              skip_next  = PAUSE_TAIL_BYTES;
            end else if (!is_ack(ps2Byte)) begin
              lk_req  = 1'b1;
              lk_make = 1'b1;
            end
          end
          ST_BREAK: begin
            lk_req     = 1'b1;
            state_next = ST_IDLE;
          end
          ST_EXT: begin
            if (ps2Byte == SC_BREAK_PFX) begin
              state_next = ST_EXT_BREAK;
            end else begin
              lk_req     = 1'b1;
              lk_ext     = 1'b1;
              lk_make    = 1'b1;
              state_next = ST_IDLE;
            end
          end
          ST_EXT_BREAK: begin
            lk_req     = 1'b1;
            lk_ext     = 1'b1;
            state_next = ST_IDLE;
          end
          ST_PAUSE_SKIP: begin
            skip_next = skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        timeout    = 1'b1;
        state_next = ST_IDLE;
        tmo_next   = '0;
        skip_next  = '0;
      end else begin
        tmo_next = tmo_cnt + 1'b1;
      end
    end
  end

  // Output logic: key vector update and event generation
  always_comb begin
    keys_next       = inputStateStorage;
    ev_valid_next   = 1'b0;
    ev_index_next   = keyEventIndex;
    ev_pressed_next = keyEventPressed;
    err_next        = overrun | timeout;
    if (overrun) begin
      keys_next = '0;
    end else if (lk_req && lk_hit && (32'(lk_index) < NKEYS)) begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        // Typematic repeats and breaks of released keys leave the bit alone
        if (i == 32'(lk_index) && inputStateStorage[i] != lk_make) begin
          keys_next[i]    = lk_make;
          ev_valid_next   = 1'b1;
          ev_index_next   = lk_index;
          ev_pressed_next = lk_make;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inputStateStorage <= '0;
      keyEventValid     <= 1'b0;
      keyEventIndex     <= '0;
      keyEventPressed   <= 1'b0;
      decodeError       <= 1'b0;
    end else begin
      inputStateStorage <= keys_next;
      keyEventValid     <= ev_valid_next;
      keyEventIndex     <= ev_index_next;
      keyEventPressed   <= ev_pressed_next;
      decodeError       <= err_next;
    end
  end

endmodule

// File: tb/tb_keyboard_state_decoder.sv
// Randomized self-checking bench for keyboard_state_decoder with a
// byte-stream reference model (prefix queue + key bit vector).

module tb_keyboard_state_decoder;
  import keyboard_state_decoder_pkg::*;

  localparam int unsigned T = 40;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [7:0]          ps2Byte = '0;
  logic                ps2ByteValid = 1'b0;
  logic [NUM_KEYS-1:0] inputStateStorage;
  logic                keyEventValid;
  logic [4:0]          keyEventIndex;
  logic                keyEventPressed;
  logic                decodeError;

  keyboard_state_decoder #(
    .TIMEOUT_CYCLES (T),
    .NKEYS          (NUM_KEYS)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ps2Byte           (ps2Byte),
    .ps2ByteValid      (ps2ByteValid),
    .inputStateStorage (inputStateStorage),
    .keyEventValid     (keyEventValid),
    .keyEventIndex     (keyEventIndex),
    .keyEventPressed   (keyEventPressed),
    .decodeError       (decodeError)
  );

  always #5 clk = ~clk;

  // Independent copy of the mapping: plain codes then extended codes
  logic [7:0] norm_codes [16] = '{8'h29, 8'h5A, 8'h2D, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23,
                                  8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  logic [7:0] ext_codes [4]   = '{8'h75, 8'h72, 8'h6B, 8'h74};

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [NUM_KEYS-1:0] mk = '0;
  logic [7:0]          pfx [$];
  int                  pause_left = 0;
  int                  quiet = 0;
  logic                e_err, e_ev, e_pr;
  int                  e_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_key(input bit ext, input logic [7:0] b);
    if (ext) begin
      for (int i = 0; i < 4; i++) if (ext_codes[i] == b) return 16 + i;
    end else begin
      for (int i = 0; i < 16; i++) if (norm_codes[i] == b) return i;
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int  k;
    bit  ext, brk;
    e_err = 1'b0;
    e_ev  = 1'b0;
    quiet = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      mk = '0; e_err = 1'b1; pfx.delete(); pause_left = 0;
      return;
    end
    if (pause_left > 0) begin pause_left--; return; end
    if (pfx.size() == 0 && b == 8'hE1) begin pause_left = 7; return; end
    if (pfx.size() == 0 && b == 8'hE0) begin pfx.push_back(b); return; end
    if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
      pfx.push_back(b);
      return;
    end
    ext = 0; brk = 0;
    foreach (pfx[i]) begin
      if (pfx[i] == 8'hE0) ext = 1;
      if (pfx[i] == 8'hF0) brk = 1;
    end
    pfx.delete();
    if (!ext && !brk && (b == 8'hFA || b == 8'hAA || b == 8'hFE)) return;
    k = find_key(ext, b);
    if (k < 0) return;
    if (mk[k] != !brk) begin
      mk[k] = !brk; e_ev = 1'b1; e_idx = k; e_pr = !brk;
    end
  endtask

  task automatic model_tick();
    e_err = 1'b0;
    e_ev  = 1'b0;
    if (pfx.size() > 0 || pause_left > 0) begin
      quiet++;
      if (quiet >= int'(T)) begin
        pfx.delete(); pause_left = 0; quiet = 0; e_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("keys", 32'(inputStateStorage), 32'(mk));
    check("event_valid", 32'(keyEventValid), 32'(e_ev));
    check("decode_error", 32'(decodeError), 32'(e_err));
    if (e_ev) begin
      check("event_index", 32'(keyEventIndex), 32'(e_idx));
      check("event_pressed", 32'(keyEventPressed), 32'(e_pr));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2Byte      = b;
    ps2ByteValid = 1'b1;
    @(posedge clk);
    model_byte(b);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    if (n == 0) return;
    @(negedge clk);
    ps2ByteValid = 1'b0;
    ps2Byte      = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_tick();
      #1;
      check_outputs();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ps2ByteValid = 1'b0;
    resetn       = 1'b0;
    #2;
    check("rst_keys", 32'(inputStateStorage), 32'h0);
    check("rst_event_valid", 32'(keyEventValid), 32'h0);
    check("rst_event_index", 32'(keyEventIndex), 32'h0);
    check("rst_event_pressed", 32'(keyEventPressed), 32'h0);
    check("rst_decode_error", 32'(decodeError), 32'h0);
    mk = '0; pfx.delete(); pause_left = 0; quiet = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic key_event(input bit ext, input bit brk, input logic [7:0] code);
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(code);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int r;
    do_reset();

    // Spacebar press then release
    send_byte(8'h29);
    check("space_set", 32'(inputStateStorage[KEY_SPACEBAR]), 32'h1);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("space_clear", 32'(inputStateStorage[KEY_SPACEBAR]), 32'h0);

    // Typematic repeat of Enter
    send_byte(8'h5A); send_byte(8'h5A); send_byte(8'h5A);
    check("enter_held", 32'(inputStateStorage[KEY_ENTER]), 32'h1);

    // Extended break of R is unmapped; FSM back in IDLE afterwards
    idle(2);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h2D);
    check("r_untouched", 32'(inputStateStorage[KEY_R]), 32'h0);
    send_byte(8'h2D);
    check("r_make", 32'(inputStateStorage[KEY_R]), 32'h1);

    // Overrun clears everything
    send_byte(8'h29); send_byte(8'h5A); send_byte(8'hFF);
    check("overrun_clear", 32'(inputStateStorage), 32'h0);
    idle(1);

    // Timeout after a lone break prefix, then a make is decoded normally
    send_byte(8'hF0);
    idle(T + 2);
    send_byte(8'h2D);
    check("r_after_timeout", 32'(inputStateStorage[KEY_R]), 32'h1);

    // Byte arriving on the expiry cycle is processed instead of timing out
    send_byte(8'h29);
    send_byte(8'hF0);
    idle(T - 1);
    send_byte(8'h29);

    // Pause sequence swallows seven bytes, even mapped ones
    send_byte(8'hE1);
    for (int i = 0; i < 7; i++) send_byte(8'h42);
    send_byte(8'h42);

    // Reset mid-sequence discards the pending break prefix
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h29);
    check("space_after_reset", 32'(inputStateStorage[KEY_SPACEBAR]), 32'h1);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        if ($urandom_range(0, 3) == 0)
          key_event(1'b1, 1'($urandom), ext_codes[$urandom_range(0, 3)]);
        else
          key_event(1'b0, 1'($urandom), norm_codes[$urandom_range(0, 15)]);
      end else if (r < 80) begin
        send_byte(8'($urandom));
      end else if (r < 85) begin
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      end else if (r < 89) begin
        send_byte(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      end else if (r < 95) begin
        send_byte(8'hF0 - 8'(16 * $urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 2))
          0: send_byte(8'hFA);
          1: send_byte(8'hAA);
          default: send_byte(8'hFE);
        endcase
      end
      if ($urandom_range(0, 29) == 0) idle(int'(T) + 3);
      else idle(int'($urandom_range(0, 3)));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/keyboard_state_decoder.md
KEYBOARD_STATE_DECODER -- requirements
Module: keyboard_state_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, the prefix-abandon timeout in clk cycles (2 ms at 50 MHz).
REQ-002 SHALL have parameter NKEYS, default `NUMBEROFKEYBOARDINPUTS, the width of the key-state vector.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic rising-edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2Byte, input, 8, the scancode byte from the PS/2 byte receiver.
REQ-006 SHALL have port ps2ByteValid, input, 1, a one-cycle strobe qualifying ps2Byte.
REQ-007 SHALL have port inputStateStorage, output, NKEYS, held key state (1 = down), indexed by the shared key-index defines.
REQ-008 SHALL have port keyEventValid, output, 1, a one-cycle pulse on any key-state bit change.
REQ-009 SHALL have port keyEventIndex, output, 5, the index of the changed key; valid with keyEventValid.
REQ-010 SHALL have port keyEventPressed, output, 1, where 1 = press and 0 = release; valid with keyEventValid.
REQ-011 SHALL have port decodeError, output, 1, a one-cycle pulse on an overrun code (0x00/0xFF) or a timeout.

Function
REQ-012 SHALL decode PS/2 scan-code set 2 using FSM states IDLE, BREAK, EXT, EXT_BREAK and PAUSE_SKIP.
REQ-013 In IDLE: 0xF0 -> BREAK; 0xE0 -> EXT; 0xE1 -> PAUSE_SKIP with skip counter = 7; any other byte is processed as a make code and the FSM stays in IDLE.
REQ-014 In BREAK: the byte is processed as a break code -> IDLE.
REQ-015 In EXT: 0xF0 -> EXT_BREAK; any other byte is processed as an extended make -> IDLE.
REQ-016 In EXT_BREAK: the byte is processed as an extended break -> IDLE.
REQ-017 In PAUSE_SKIP: each valid byte decrements the counter; at 0 -> IDLE; no state change.
REQ-018 Make/break lookup: codes in the shared code table set/clear the mapped bit; unmapped codes are silently ignored.
REQ-019 Minimum mapped set: Spacebar 0x29, Enter 0x5A, R 0x2D, plus the piano note keys defined in the shared table.
REQ-020 Extended codes SHALL use a separate table; codes absent from it are ignored.
REQ-021 Output latency: inputStateStorage and the event outputs update on the clk edge after the ps2ByteValid cycle (1-cycle latency).
REQ-022 Typematic repeat (a make on a key already set) or a break on a key already clear: no bit change, no keyEventValid.
REQ-023 Overrun code 0x00 or 0xFF in any state: clear all of inputStateStorage, pulse decodeError, -> IDLE, no keyEventValid.
REQ-024 A timeout counter SHALL run while in BREAK, EXT, EXT_BREAK or PAUSE_SKIP, reloading on each valid byte.
REQ-025 On reaching TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and pulse decodeError; key state is unchanged.
REQ-026 Ack/BAT bytes (0xFA, 0xAA, 0xFE) received in IDLE are ignored.
REQ-027 At most one key bit SHALL change per valid byte, so no simultaneous events can occur.
REQ-028 A ps2ByteValid arriving in the same cycle as the timeout expiry SHALL be processed; the timeout is discarded.

Reset
REQ-029 resetn low SHALL asynchronously force: FSM = IDLE; inputStateStorage, keyEventValid, keyEventPressed, decodeError, keyEventIndex and counters all = 0.
REQ-030 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix.

Structure
REQ-031 Key-index defines, NUMBEROFKEYBOARDINPUTS, and the scancode-to-index tables SHALL live in the shared macro header.
REQ-032 A sub-module scancode_lookup SHALL map {extended, byte} to {hit, index}.

Verification
REQ-033 0x29 -> bit keySpacebar = 1, keyEventValid = 1 with Index = keySpacebar, Pressed = 1; then F0 29 -> bit = 0, Pressed = 0.
REQ-034 5A 5A 5A -> exactly one keyEventValid, bit keyEnter remains 1.
REQ-035 E0, then 0xF0, then 0x2D -> R bit unchanged and no keyEventValid (extended R unmapped); the FSM returns to IDLE.
REQ-036 Press 0x29 and 0x5A, then send 0xFF -> all bits 0 and decodeError pulses once.
REQ-037 0xF0 followed by no bytes for TIMEOUT_CYCLES -> decodeError pulse; a subsequent 0x2D sets bit keyR as a make.
REQ-038 resetn asserted after 0xF0, released, then 0x29 -> spacebar bit set as a make.
